// File: rtl/srm_datapath.sv
// srm_datapath: register file, A/B/C regs, shifter, ALU and status; SRM_DP_STATUS_NV_EN adds N/V flags
module srm_datapath #(
  parameter int DW = 16,
  parameter int NREGS = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    rn,
  input  logic [2:0]    rd,
  input  logic [2:0]    rm,
  input  logic [2:0]    nsel,
  input  logic [3:0]    vsel,
  input  logic [DW-1:0] mdata,
  input  logic [DW-1:0] sximm8,
  input  logic [DW-1:0] sximm5,
  input  logic [7:0]    PC,
  input  logic          write,
  input  logic          loada,
  input  logic          loadb,
  input  logic [1:0]    shift,
  input  logic          asel,
  input  logic          bsel,
  input  logic [1:0]    alu_op,
  input  logic          loadc,
  input  logic          loads,
  output logic [DW-1:0] datapath_out,
  output logic          Z,
  output logic          N,
  output logic          V
);
  logic [DW-1:0] regs [NREGS];
  logic [DW-1:0] a, b, c, wdata, rdata, sh, ain, bin, res;
  logic [2:0] idx;
  logic idx_ok, z;
  always_comb begin
    idx_ok = nsel == 3'b001 || nsel == 3'b010 || nsel == 3'b100;
    idx = nsel == 3'b001 ? rn : nsel == 3'b010 ? rd : nsel == 3'b100 ? rm : 3'd0;
    wdata = vsel == 4'b0001 ? mdata :
            vsel == 4'b0010 ? sximm8 :
            vsel == 4'b0100 ? {{(DW-8){1'b0}}, PC} :
            vsel == 4'b1000 ? c : '0;
    rdata = regs[idx];
    sh = shift == 2'b00 ? b :
         shift == 2'b01 ? {b[DW-2:0], 1'b0} :
         shift == 2'b10 ? {1'b0, b[DW-1:1]} : {b[DW-1], b[DW-1:1]};
    ain = asel ? '0 : a;
    bin = bsel ? sximm5 : sh;
    res = alu_op == 2'b00 ? ain + bin :
          alu_op == 2'b01 ? ain - bin :
          alu_op == 2'b10 ? (ain & bin) : ~bin;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      a <= '0;
      b <= '0;
      c <= '0;
      z <= 1'b0;
    end else begin
      if (write && idx_ok) regs[idx] <= wdata;
      if (loada) a <= rdata;
      if (loadb) b <= rdata;
      if (loadc) c <= res;
      if (loads) z <= res == '0;
    end
  end
  assign datapath_out = c;
  assign Z = z;
`ifdef SRM_DP_STATUS_NV_EN
  logic n_q, v_q, v_nxt;
  always_comb
    v_nxt = alu_op == 2'b00 ? (ain[DW-1] == bin[DW-1]) && (res[DW-1] != ain[DW-1]) :
            alu_op == 2'b01 ? (ain[DW-1] != bin[DW-1]) && (res[DW-1] != ain[DW-1]) : 1'b0;
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else if (loads) begin
      n_q <= res[DW-1];
      v_q <= v_nxt;
    end
  end
  assign N = n_q;
  assign V = v_q;
`else
  assign N = 1'b0;
  assign V = 1'b0;
`endif
endmodule
